// File: rtl/ps2_keyboard_tx.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_tx
// Device-side PS/2 transmitter that behaves like a keyboard. Scan-code bytes
// from the host logic are queued in a small FIFO. Each byte is sent on
// ps2_clk/ps2_data as an 11-bit device-to-host frame:
//   start 0, d[0]..d[7] LSB first, odd parity, stop 1.
// The data line changes only while ps2_clk is high, so the receiver can
// sample it on the falling edge of ps2_clk.
//
// Optional feature macro: PS2_TX_PERR_INJECT_EN
//   When this macro is defined, the module has an extra input perr_inj. It is
//   sampled on the cycle a byte is popped from the FIFO. If it is 1, that
//   frame is sent with an inverted (even) parity bit.
//
// Ports
//   clk       in   system clock, every register uses its rising edge
//   clrn      in   asynchronous active-low reset
//   wr_en     in   push wr_data into the FIFO in this cycle
//   wr_data   in   [7:0] scan-code byte
//   perr_inj  in   (only with PS2_TX_PERR_INJECT_EN) corrupt the parity bit
//   full      out  FIFO holds DEPTH bytes
//   empty     out  FIFO holds no bytes
//   busy      out  a frame or the idle gap after it is in progress
//   overflow  out  sticky; set when a push is dropped because the FIFO is full
//   ps2_clk   out  PS/2 clock line, 1 when idle
//   ps2_data  out  PS/2 data line, 1 when idle
// ---------------------------------------------------------------------------
module ps2_keyboard_tx #(
    parameter int CLK_DIV = 4,  // half-period of ps2_clk in clk cycles (>=2)
    parameter int GAP     = 8,  // idle clk cycles between frames (>=1)
    parameter int DEPTH   = 8   // FIFO depth in bytes (power of 2, >=2)
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
`ifdef PS2_TX_PERR_INJECT_EN
    input  logic       perr_inj,
`endif
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(((CLK_DIV > GAP) ? CLK_DIV : GAP) + 1);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

    // ---------------- FIFO ----------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q, overflow_q;
    logic          push, pop;
    state_t        state_q;

    // full_q and empty_q come from the registered count. Because of this, a
    // pop frees its slot for writers only from the next cycle.
    assign push = wr_en && !full_q;
    assign pop  = (state_q == S_IDLE) && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array is not reset; the pointers and the count define its state.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
            if (wr_en && full_q) overflow_q <= 1'b1;
        end
    end

    // ---------------- frame assembly ----------------
    logic [7:0]  head;
    logic        parity_bit;
    logic [10:0] frame_w;

    assign head = mem_q[rd_ptr_q];
`ifdef PS2_TX_PERR_INJECT_EN
    assign parity_bit = ~(^head) ^ perr_inj;
`else
    assign parity_bit = ~(^head);
`endif
    assign frame_w = {1'b1, parity_bit, head, 1'b0};

    // ---------------- serializer FSM ----------------
    // Bit 0 of the frame goes directly into ps2_data_q when the byte is
    // loaded. Only the remaining ten bits are kept in shift_q.
    logic [9:0]    shift_q;
    logic [3:0]    bitcnt_q;
    logic [TW-1:0] tmr_q;
    logic          ps2_clk_q, ps2_data_q, busy_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= S_IDLE;
            shift_q    <= '1;
            bitcnt_q   <= '0;
            tmr_q      <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty_q) begin
                        shift_q    <= frame_w[10:1];
                        bitcnt_q   <= '0;
                        tmr_q      <= TW'(CLK_DIV - 1);
                        ps2_clk_q  <= 1'b1;
                        ps2_data_q <= frame_w[0];
                        busy_q     <= 1'b1;
                        state_q    <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (tmr_q == '0) begin
                        tmr_q     <= TW'(CLK_DIV - 1);
                        ps2_clk_q <= 1'b0;
                        state_q   <= S_LOW;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                S_LOW: begin
                    if (tmr_q == '0) begin
                        ps2_clk_q <= 1'b1;
                        if (bitcnt_q == 4'd10) begin
                            tmr_q      <= TW'(GAP - 1);
                            ps2_data_q <= 1'b1;
                            state_q    <= S_GAP;
                        end else begin
                            // The next bit appears together with the rising
                            // edge. It stays stable for a whole high phase
                            // before the next falling edge.
                            ps2_data_q <= shift_q[0];
                            shift_q    <= {1'b1, shift_q[9:1]};
                            bitcnt_q   <= bitcnt_q + 1'b1;
                            tmr_q      <= TW'(CLK_DIV - 1);
                            state_q    <= S_HIGH;
                        end
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                S_GAP: begin
                    if (tmr_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign ps2_clk  = ps2_clk_q;
    assign ps2_data = ps2_data_q;

endmodule
